apb_cmd_master: RTL and testbench

Parametrised, synthesizable APB master that replaces hand-sequenced APB config writes in the matrix-multiplier bench and SoC glue. It buffers read/write commands in a small FIFO and issues them as APB transfers. It supports `pready` wait states, `pslverr`, back-to-back transfers and a wait-state timeout. It sits between any command source (bench driver, boot ROM sequencer) and the `top` config bus.

---
 rtl/apb_cmd_master.sv | 194 +++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - Command-FIFO-fed APB master with wait-state timeout
//
// Buffers read/write commands in a circular FIFO and issues them in order as
// APB transfers (IDLE -> SETUP -> ACCESS), back-to-back when commands are queued.
// One response is produced per accepted command.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command push handshake
//   cmd_write, cmd_addr, cmd_wdata     command fields (wdata ignored for reads)
//   rsp_valid, rsp_rdata, rsp_error    one-cycle completion pulse with read data / error
//   busy                               FIFO non-empty or transfer in flight (registered)
//   paddr, pwdata, pwrite, psel, penable   APB master outputs
//   prdata, pready, pslverr            APB slave responses
module apb_cmd_master #(
    parameter int ADDR_W         = 3,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int ENT_W    = 1 + ADDR_W + DATA_W;
    // The wait counter never needs to exceed TIMEOUT_CYCLES-1: the ACCESS cycle
    // that would reach TIMEOUT_CYCLES is the one that terminates the transfer.
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST_CNT = TMO_LAST[CNT_W-1:0];
    localparam logic [PTR_W:0]   FULL_CNT     = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

    state_e state_q, state_d;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              cmd_ready_q;

    logic              push, pop, fifo_nonempty, timed_out, xfer_done;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              busy_q;

    assign push          = cmd_valid && cmd_ready_q;
    assign fifo_nonempty = (count_q != '0);
    assign {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q];

    assign timed_out = (TIMEOUT_CYCLES != 0) && !pready && (wait_cnt_q == TMO_LAST_CNT);
    assign xfer_done = (state_q == S_ACCESS) && (pready || timed_out);
    // Only entries already counted before this edge are visible: no fall-through.
    assign pop       = fifo_nonempty && ((state_q == S_IDLE) || xfer_done);

    // FIFO storage; read commands store zero data so pwdata is 0 for reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : {DATA_W{1'b0}}};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != FULL_CNT);
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_cnt_q  <= wait_cnt_d;
            // Registered view of the pre-edge occupancy/state.
            busy_q      <= fifo_nonempty || (state_q != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fifo_nonempty) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (xfer_done) state_d = fifo_nonempty ? S_SETUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output next-values
    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_SETUP: penable_d = 1'b1;
            S_ACCESS: begin
                if (xfer_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = pready ? pslverr : 1'b1;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A pop always launches a SETUP phase, overriding the idle return above.
        if (pop) begin
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            pwrite_d   = head_write;
            paddr_d    = head_addr;
            pwdata_d   = head_wdata;
            wait_cnt_d = '0;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = busy_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - Randomized self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_error, busy, pwrite, psel, penable;
    logic [DW-1:0] rsp_rdata, pwdata;
    logic [AW-1:0] paddr;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            acc_at;
    } cmd_t;

    int total = 0;
    int bad   = 0;

    // Timeline model: each command is issued (SETUP) at the first edge after it
    // was accepted at which nothing is in flight; ACCESS begins one edge later.
    cmd_t acc_q[$];
    cmd_t cur, drv_cmd;
    bit   inflight = 0;
    int   setup_at = 0, waits = 0, cyc = 0;
    bit   drv_accept = 0, drv_pready = 0, drv_pslverr = 0;
    logic [DW-1:0] drv_prdata = '0;
    bit   prev_cond = 0;
    int   n_acc = 0, n_rsp = 0, nr_seen = 0;
    int   p_valid = 0, p_ready = 100;
    logic [AW+DW:0] dir_q[$];
    logic [DW+1:0]  rdy_script[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_psel",      32'(psel), 0);
        chk("rst_penable",   32'(penable), 0);
        chk("rst_pwrite",    32'(pwrite), 0);
        chk("rst_paddr",     32'(paddr), 0);
        chk("rst_pwdata",    32'(pwdata), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_error", 32'(rsp_error), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
    endtask

    task automatic step();
        bit            done;
        logic [DW-1:0] e_rdata;
        logic          e_err;
        bit            cur_access;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        done    = 0;
        e_rdata = '0;
        e_err   = 1'b0;
        if (inflight && cyc >= setup_at + 2) begin
            if (drv_pready) begin
                done    = 1;
                e_rdata = cur.wr ? '0 : drv_prdata;
                e_err   = drv_pslverr;
            end else if (waits + 1 == TMO) begin
                done  = 1;
                e_err = 1'b1;
            end else begin
                waits++;
            end
            if (done) inflight = 0;
        end
        if (!inflight && acc_q.size() > 0 && acc_q[0].acc_at < cyc) begin
            cur      = acc_q.pop_front();
            inflight = 1;
            setup_at = cyc;
            waits    = 0;
        end
        if (drv_accept) begin
            drv_cmd.acc_at = cyc;
            acc_q.push_back(drv_cmd);
            n_acc++;
        end

        chk("psel", 32'(psel), 32'(inflight));
        chk("penable", 32'(penable), 32'(inflight && cyc >= setup_at + 1));
        if (inflight) begin
            chk("paddr", 32'(paddr), 32'(cur.addr));
            chk("pwrite", 32'(pwrite), 32'(cur.wr));
            chk("pwdata", 32'(pwdata), 32'(cur.wr ? cur.wdata : DW'(0)));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(done));
        if (done) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
            chk("rsp_error", 32'(rsp_error), 32'(e_err));
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(acc_q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(prev_cond));
        prev_cond = inflight || (acc_q.size() != 0);
        if (rsp_valid === 1'b1) n_rsp++;
        if (cmd_ready === 1'b0) nr_seen++;

        // Slave response for the coming edge
        cur_access = inflight && (cyc >= setup_at + 1);
        if (cur_access && rdy_script.size() > 0) begin
            {pready, pslverr, prdata} = rdy_script.pop_front();
        end else begin
            pready  = ($urandom_range(99) < p_ready);
            pslverr = ($urandom_range(7) == 0);
            prdata  = DW'($urandom);
        end
        drv_pready  = pready;
        drv_pslverr = pslverr;
        drv_prdata  = prdata;

        // Command source
        if (dir_q.size() > 0) begin
            cmd_valid = 1'b1;
            {cmd_write, cmd_addr, cmd_wdata} = dir_q[0];
        end else begin
            cmd_valid = ($urandom_range(99) < p_valid);
            cmd_write = 1'($urandom_range(1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
        end
        drv_accept = cmd_valid && (acc_q.size() < DEPTH);
        if (drv_accept && dir_q.size() > 0) void'(dir_q.pop_front());
        drv_cmd.wr    = cmd_write;
        drv_cmd.addr  = cmd_addr;
        drv_cmd.wdata = cmd_wdata;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (n < max && !(dir_q.size() == 0 && !inflight && acc_q.size() == 0 && !drv_accept)) begin
            step();
            n++;
        end
        repeat (2) step();
        chk("drain_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        #1;
        check_reset_vals();
        acc_q.delete();
        dir_q.delete();
        rdy_script.delete();
        inflight   = 0;
        drv_accept = 0;
        prev_cond  = 0;
        n_acc      = 0;
        n_rsp      = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bdata[7];
        bit  reached;
        bdata = '{0, 0, 0, 32, 32, 32, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        reset_n = 1'b1;

        // Single write
        p_valid = 0;
        p_ready = 100;
        dir_q.push_back({1'b1, 3'd3, 16'h0020});
        drain(50);

        // Config burst
        for (int i = 0; i < 7; i++) dir_q.push_back({1'b1, AW'(i), DW'(bdata[i])});
        drain(60);

        // Wait states then slave error on a read
        for (int i = 0; i < 3; i++) rdy_script.push_back({1'b0, 1'b0, 16'h0000});
        rdy_script.push_back({1'b1, 1'b1, 16'hBEEF});
        dir_q.push_back({1'b0, 3'd5, 16'h0000});
        drain(50);

        // Timeout followed by a normal command
        for (int i = 0; i < TMO; i++) rdy_script.push_back({1'b0, 1'b0, 16'h5555});
        dir_q.push_back({1'b0, 3'd2, 16'h0000});
        dir_q.push_back({1'b1, 3'd1, 16'h1234});
        drain(60);

        // Backpressure: slave stalls, more offers than FIFO slots
        n_acc   = 0;
        n_rsp   = 0;
        nr_seen = 0;
        p_ready = 0;
        for (int i = 0; i < 12; i++) dir_q.push_back({1'($urandom_range(1)), AW'(i), DW'($urandom)});
        for (int i = 0; i < 200 && dir_q.size() > 0; i++) step();
        chk("bp_stall_seen", 32'(nr_seen > 0), 1);
        p_ready = 100;
        drain(200);
        chk("bp_rsp_count", 32'(n_rsp), 32'(n_acc));

        // Reset during ACCESS with 3 commands queued
        p_ready = 0;
        for (int i = 0; i < 4; i++) dir_q.push_back({1'b1, AW'(i + 4), DW'(16'hA0 + i)});
        reached = 0;
        for (int i = 0; i < 30 && !reached; i++) begin
            step();
            reached = inflight && (cyc >= setup_at + 1) && (acc_q.size() == 3);
        end
        chk("rst_mid_reached", 32'(reached), 1);
        do_reset();
        p_ready = 100;
        step();
        dir_q.push_back({1'b1, 3'd6, 16'h00AA});
        drain(50);
        chk("rst_post_count", 32'(n_rsp), 32'(n_acc));

        // Random traffic
        for (int blk = 0; blk < 15; blk++) begin
            p_valid = $urandom_range(100);
            p_ready = $urandom_range(100);
            repeat (200) step();
        end
        p_valid = 0;
        p_ready = 100;
        drain(400);
        chk("rsp_count", 32'(n_rsp), 32'(n_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
